// File: rtl/instruction_fetch_unit.sv
// Fetch stage: keeps the fetch PC, issues word reads to instruction memory
// and buffers in-order responses with their PCs for the decode stage.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [6:0]  if_opcode
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc;
    logic [CW-1:0] live_cnt;
    logic [CW-1:0] stale_cnt;
    logic [CW-1:0] fifo_cnt;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   pc_mem    [FIFO_DEPTH];
    logic [31:0]   instr_mem [FIFO_DEPTH];

    logic          issue;
    logic          pop;
    logic          push;
    logic          rsp_stale;
    logic          rsp_live;
    logic          rsp_used;
    logic [CW:0]   inflight;
    logic [CW:0]   credit_used;
    logic [31:0]   rsp_pc;
    logic          unused_bits;

    assign unused_bits = ^redirect_pc[1:0];

    assign rsp_stale = imem_rsp_valid && !rst && (stale_cnt != '0);
    assign rsp_live  = imem_rsp_valid && !rst && (stale_cnt == '0)
                       && (live_cnt != '0);
    assign rsp_used  = rsp_stale || rsp_live;
    assign push      = rsp_live && !redirect_valid;

    assign if_valid  = !rst && !redirect_valid && (fifo_cnt != '0);
    assign pop       = if_valid && if_ready;
    assign if_instr  = if_valid ? instr_mem[rd_ptr] : '0;
    assign if_pc     = if_valid ? pc_mem[rd_ptr] : '0;
    assign if_opcode = if_instr[6:0];

    // A slot freed by this cycle's pop is credited, so a 2-deep buffer
    // sustains one fetch per cycle without ever overflowing.
    assign inflight    = {1'b0, live_cnt} + {1'b0, stale_cnt};
    assign credit_used = {1'b0, live_cnt} + {1'b0, fifo_cnt}
                         - {{CW{1'b0}}, pop};

    assign imem_req_valid = !rst && !redirect_valid
                            && (inflight < DEPTH)
                            && (credit_used < DEPTH);
    assign imem_req_addr  = fetch_pc;
    assign issue          = imem_req_valid && imem_req_ready;

    // Live requests are consecutive words since the last redirect, so the
    // oldest one sits live_cnt words behind fetch_pc.
    assign rsp_pc = fetch_pc - {{(30-CW){1'b0}}, live_cnt, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            live_cnt  <= '0;
            stale_cnt <= '0;
            fifo_cnt  <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else if (redirect_valid) begin
            fetch_pc  <= {redirect_pc[31:2], 2'b00};
            stale_cnt <= stale_cnt + live_cnt - CW'(rsp_used);
            live_cnt  <= '0;
            fifo_cnt  <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            stale_cnt <= stale_cnt - CW'(rsp_stale);
            live_cnt  <= live_cnt + CW'(issue) - CW'(rsp_live);
            fifo_cnt  <= fifo_cnt + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= rsp_pc;
            instr_mem[wr_ptr] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: queue-based fetch model, in-order
// memory with random latency, directed scenarios plus random traffic.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          D      = 2;
    localparam int          NLOG   = 4096;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [6:0]  if_opcode;

    instruction_fetch_unit #(
        .RESET_PC  (RST_PC),
        .FIFO_DEPTH(D)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_opcode     (if_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        bit          live;
    } out_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          orphan;
    } mreq_t;

    // Reference model state
    out_t        q_out[$];
    logic [31:0] ibuf_q[$];
    logic [31:0] fpc;
    mreq_t       mem_q[$];
    int          last_due;

    // Stimulus knobs
    bit          c_rst;
    bit          c_redir;
    bit          c_ifr;
    logic [31:0] c_rpc;
    int          p_ready;
    int          lat_lo;
    int          lat_hi;

    int cyc;
    int n_cmp;
    int n_bad;

    logic        obs_rv [NLOG];
    logic        obs_acc[NLOG];
    logic [31:0] obs_ra [NLOG];
    logic        obs_iv [NLOG];
    logic [31:0] obs_ipc[NLOG];
    logic [6:0]  obs_op [NLOG];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h1357_2468;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        bit          rsp;
        bit          orph;
        bit          mrdy;
        bit          e_ifv;
        bit          e_pop;
        bit          e_reqv;
        int          live;
        int          lat;
        int          due;
        logic [31:0] e_pc;
        logic [31:0] w;
        out_t        o;
        mreq_t       m;

        rsp  = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        orph = 1'b0;
        foreach (mem_q[i]) if (mem_q[i].orphan) orph = 1'b1;
        mrdy = !orph && ($urandom_range(99) < p_ready);

        rst            = c_rst;
        redirect_valid = c_redir;
        redirect_pc    = c_redir ? c_rpc : $urandom();
        if_ready       = c_ifr;
        imem_req_ready = mrdy;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(mem_q[0].addr) : $urandom();

        @(negedge clk);

        live = 0;
        foreach (q_out[i]) if (q_out[i].live) live++;
        e_ifv  = !c_rst && !c_redir && (ibuf_q.size() > 0);
        e_pop  = e_ifv && c_ifr;
        e_reqv = !c_rst && !c_redir && (q_out.size() < D)
                 && ((live + ibuf_q.size() - (e_pop ? 1 : 0)) < D);
        e_pc   = e_ifv ? ibuf_q[0] : 32'h0;
        w      = e_ifv ? mem_word(e_pc) : 32'h0;

        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, e_reqv});
        chk("req_addr", imem_req_addr, fpc);
        chk("if_valid", {31'b0, if_valid}, {31'b0, e_ifv});
        chk("if_pc", if_pc, e_pc);
        chk("if_instr", if_instr, w);
        chk("if_opcode", {25'b0, if_opcode}, {25'b0, w[6:0]});

        if (cyc < NLOG) begin
            obs_rv[cyc]  = imem_req_valid;
            obs_acc[cyc] = imem_req_valid && mrdy;
            obs_ra[cyc]  = imem_req_addr;
            obs_iv[cyc]  = if_valid;
            obs_ipc[cyc] = if_pc;
            obs_op[cyc]  = if_opcode;
        end

        if (rsp) void'(mem_q.pop_front());

        if (c_rst) begin
            q_out.delete();
            ibuf_q.delete();
            fpc = RST_PC;
            for (int i = 0; i < mem_q.size(); i++) begin
                m = mem_q[i];
                m.orphan = 1'b1;
                mem_q[i] = m;
            end
        end else if (c_redir) begin
            if (rsp && q_out.size() > 0) void'(q_out.pop_front());
            for (int i = 0; i < q_out.size(); i++) begin
                o = q_out[i];
                o.live = 1'b0;
                q_out[i] = o;
            end
            ibuf_q.delete();
            fpc = {c_rpc[31:2], 2'b00};
        end else begin
            if (e_pop) void'(ibuf_q.pop_front());
            if (rsp && q_out.size() > 0) begin
                o = q_out.pop_front();
                if (o.live) ibuf_q.push_back(o.pc);
            end
            if (e_reqv && mrdy) begin
                o.pc   = fpc;
                o.live = 1'b1;
                q_out.push_back(o);
                lat = $urandom_range(lat_hi, lat_lo);
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                m.addr   = fpc;
                m.due    = due;
                m.orphan = 1'b0;
                mem_q.push_back(m);
                fpc = fpc + 32'd4;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        c_rst   = 1'b1;
        c_redir = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i >= 1 && mem_q.size() == 0) break;
        end
        chk("rst_req_valid", {31'b0, obs_rv[cyc-1]}, 32'h0);
        chk("rst_if_valid", {31'b0, obs_iv[cyc-1]}, 32'h0);
        chk("rst_if_pc", obs_ipc[cyc-1], 32'h0);
        c_rst = 1'b0;
    endtask

    task automatic first_valid(input string nm, input int from,
                               input int to, input logic [31:0] exp_pc);
        bit          found;
        logic [31:0] pc;
        logic [31:0] w;
        logic [6:0]  op;
        found = 1'b0;
        pc    = 32'hFFFF_FFFF;
        op    = 7'h0;
        for (int k = from; k <= to; k++) begin
            if (!found && obs_iv[k]) begin
                found = 1'b1;
                pc    = obs_ipc[k];
                op    = obs_op[k];
            end
        end
        w = mem_word(exp_pc);
        chk({nm, "_found"}, {31'b0, found}, 32'h1);
        chk({nm, "_pc"}, pc, exp_pc);
        chk({nm, "_opcode"}, {25'b0, op}, {25'b0, w[6:0]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1);
    end

    initial begin
        int c0;
        int c1;
        int rc;
        int nreq;

        n_cmp    = 0;
        n_bad    = 0;
        cyc      = 0;
        last_due = 0;
        fpc      = RST_PC;
        c_rst    = 1'b1;
        c_redir  = 1'b0;
        c_ifr    = 1'b1;
        c_rpc    = 32'h0;
        p_ready  = 100;
        lat_lo   = 1;
        lat_hi   = 1;

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        @(posedge clk);
        #1;

        // Streaming with 1-cycle memory
        do_reset();
        c0 = cyc;
        run(8);
        chk("A_req0_v", {31'b0, obs_rv[c0]}, 32'h1);
        chk("A_req0", obs_ra[c0], 32'h0);
        chk("A_req1", obs_ra[c0+1], 32'h4);
        chk("A_req2_v", {31'b0, obs_rv[c0+2]}, 32'h1);
        chk("A_req2", obs_ra[c0+2], 32'h8);
        chk("A_if0", obs_ipc[c0+2], 32'h0);
        chk("A_if1", obs_ipc[c0+3], 32'h4);
        chk("A_if2", obs_ipc[c0+4], 32'h8);

        // Decode stalled: only FIFO_DEPTH requests
        do_reset();
        c_ifr = 1'b0;
        c0 = cyc;
        run(10);
        nreq = 0;
        for (int k = c0; k < c0 + 10; k++) nreq += obs_acc[k] ? 1 : 0;
        chk("B_req_count", nreq, 2);
        chk("B_req_v_end", {31'b0, obs_rv[c0+9]}, 32'h0);
        chk("B_addr_end", obs_ra[c0+9], 32'h8);
        chk("B_head_pc", obs_ipc[c0+9], 32'h0);
        c_ifr = 1'b1;
        c1 = cyc;
        run(6);
        chk("B_resume_v", {31'b0, obs_rv[c1]}, 32'h1);
        chk("B_resume", obs_ra[c1], 32'h8);
        chk("B_pop0", obs_ipc[c1], 32'h0);
        chk("B_pop1", obs_ipc[c1+1], 32'h4);

        // Redirect with two requests in flight
        do_reset();
        lat_lo = 2;
        lat_hi = 2;
        run(2);
        c_redir = 1'b1;
        c_rpc   = 32'h0000_0103;
        rc = cyc;
        run(1);
        c_redir = 1'b0;
        run(8);
        chk("C_tgt_v", {31'b0, obs_rv[rc+1]}, 32'h1);
        chk("C_tgt", obs_ra[rc+1], 32'h100);
        first_valid("C_first", rc + 1, rc + 8, 32'h100);

        // Redirect colliding with a response and a valid head
        do_reset();
        lat_lo = 1;
        lat_hi = 1;
        run(6);
        c_redir = 1'b1;
        c_rpc   = 32'h0000_0200;
        rc = cyc;
        run(1);
        c_redir = 1'b0;
        run(6);
        chk("D_if_gated", {31'b0, obs_iv[rc]}, 32'h0);
        first_valid("D_first", rc + 1, rc + 6, 32'h200);

        // Address wrap
        do_reset();
        run(3);
        c_redir = 1'b1;
        c_rpc   = 32'hFFFF_FFFC;
        rc = cyc;
        run(1);
        c_redir = 1'b0;
        run(6);
        chk("E_req_top", obs_ra[rc+1], 32'hFFFF_FFFC);
        chk("E_req_wrap_v", {31'b0, obs_rv[rc+2]}, 32'h1);
        chk("E_req_wrap", obs_ra[rc+2], 32'h0);
        chk("E_if_top", obs_ipc[rc+3], 32'hFFFF_FFFC);
        chk("E_if_wrap", obs_ipc[rc+4], 32'h0);

        // Reset with outstanding requests and late responses
        do_reset();
        lat_lo = 3;
        lat_hi = 3;
        run(2);
        c_rst = 1'b1;
        rc = cyc;
        run(1);
        c_rst = 1'b0;
        run(12);
        chk("F_rst_req_v", {31'b0, obs_rv[rc]}, 32'h0);
        chk("F_post_req_v", {31'b0, obs_rv[rc+1]}, 32'h1);
        chk("F_post_addr", obs_ra[rc+1], RST_PC);
        for (int k = rc; k <= rc + 5; k++)
            chk("F_if_quiet", {31'b0, obs_iv[k]}, 32'h0);
        first_valid("F_first", rc + 1, rc + 12, RST_PC);

        // Random traffic
        lat_lo  = 1;
        lat_hi  = 3;
        p_ready = 70;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) p_ready = $urandom_range(100, 30);
            c_rst   = ($urandom_range(299) == 0);
            c_redir = !c_rst && ($urandom_range(99) < 4);
            c_rpc   = ($urandom_range(3) == 0)
                      ? (32'hFFFF_FFF0 | $urandom_range(15))
                      : $urandom();
            c_ifr   = ($urandom_range(99) < 75);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
